// File: rtl/seg_scan_pkg.sv
// Shared constants, state type and width helper for the 8-digit segment scanner.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;

  typedef enum logic {
    GUARD = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  function automatic int clog2(input int unsigned v);
    int r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Display-side bundle of the scanner: segment inputs, enable and the multiplexed outputs.
// SEG_SCAN_BRIGHTNESS_EN adds the 3-bit brightness input.
interface seg_scan_if;
  logic       en;
  logic [6:0] led0, led1, led2, led3, led4, led5, led6, led7;
  logic [7:0] an;
  logic [6:0] seg;
  logic       frame_tick;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [2:0] bright;

  modport master (output en, led0, led1, led2, led3, led4, led5, led6, led7, bright,
                  input  an, seg, frame_tick);
  modport slave  (input  en, led0, led1, led2, led3, led4, led5, led6, led7, bright,
                  output an, seg, frame_tick);
`else
  modport master (output en, led0, led1, led2, led3, led4, led5, led6, led7,
                  input  an, seg, frame_tick);
  modport slave  (input  en, led0, led1, led2, led3, led4, led5, led6, led7,
                  output an, seg, frame_tick);
`endif
endinterface

// File: rtl/scan_tick_gen.sv
// Free-running slot counter; reports the position inside the slot and the last-cycle wrap.
module scan_tick_gen
  import seg_scan_pkg::*;
#(
  parameter  int SLOT_CYC = 6250,
  localparam int CW       = clog2(SLOT_CYC)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] o_slot_pos,
  output logic          o_slot_wrap
);

  logic [CW-1:0] r_slot_cnt;

  assign o_slot_wrap = (r_slot_cnt == CW'(SLOT_CYC - 1));
  assign o_slot_pos  = r_slot_cnt;

  always_ff @(posedge clk) begin
    if (rst)              r_slot_cnt <= '0;
    else if (o_slot_wrap) r_slot_cnt <= '0;
    else                  r_slot_cnt <= r_slot_cnt + 1'b1;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scanner with per-frame snapshot and inter-digit guard.
// Optional PWM brightness control when SEG_SCAN_BRIGHTNESS_EN is defined.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter  int SLOT_CYC  = 6250,
  parameter  int GUARD_CYC = 64,
  localparam int CW        = clog2(SLOT_CYC)
) (
  input logic        clk,
  input logic        rst,
  seg_scan_if.slave  bus
);

  logic [CW-1:0] w_slot_pos;
  logic          w_slot_wrap;
  logic          w_frame_wrap;
  logic          w_lit;
  logic [6:0]    w_led [NUM_DIGITS];

  scan_state_t   r_state;
  logic [2:0]    r_dig;
  logic [6:0]    r_snap [NUM_DIGITS];
  logic          r_snap_vld;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_frame_tick;

  scan_tick_gen #(.SLOT_CYC(SLOT_CYC)) u_tick (
    .clk         (clk),
    .rst         (rst),
    .o_slot_pos  (w_slot_pos),
    .o_slot_wrap (w_slot_wrap)
  );

  assign w_led[0] = bus.led0;
  assign w_led[1] = bus.led1;
  assign w_led[2] = bus.led2;
  assign w_led[3] = bus.led3;
  assign w_led[4] = bus.led4;
  assign w_led[5] = bus.led5;
  assign w_led[6] = bus.led6;
  assign w_led[7] = bus.led7;

  assign w_frame_wrap = w_slot_wrap && (r_dig == 3'd7);

`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [2:0] r_pwm_cnt;
  logic [2:0] r_bright_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm_cnt  <= '0;
      r_bright_q <= 3'd7;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 3'd1;
      if (w_frame_wrap) r_bright_q <= bus.bright;
    end
  end

  assign w_lit = (r_state == ON) && r_snap_vld && (r_pwm_cnt <= r_bright_q);
`else
  assign w_lit = (r_state == ON) && r_snap_vld;
`endif

  // Digit index, guard/on phase and frame snapshot; nothing lights until the first capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= GUARD;
      r_dig      <= '0;
      r_snap_vld <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= SEG_OFF;
    end else begin
      if (w_slot_wrap) begin
        r_state <= GUARD;
        r_dig   <= r_dig + 3'd1;
      end else if (w_slot_pos == CW'(GUARD_CYC - 1)) begin
        r_state <= ON;
      end
      if (w_frame_wrap) begin
        r_snap_vld <= 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= w_led[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_wrap;
      if (bus.en && w_lit) begin
        r_an  <= ~(8'd1 << r_dig);
        r_seg <= r_snap[r_dig];
      end else begin
        r_an  <= AN_OFF;
        r_seg <= SEG_OFF;
      end
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: hand-derived checkpoint table, directed corner sequences and
// randomized traffic against a cycle-indexed schedule model.
module tb_seg_scan_driver;
  import seg_scan_pkg::*;

  localparam int SLOT  = 16;
  localparam int GUARD = 2;
  localparam int FRAME = 8 * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if bus();

  seg_scan_driver #(.SLOT_CYC(SLOT), .GUARD_CYC(GUARD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] led [8];
  assign bus.led0 = led[0];
  assign bus.led1 = led[1];
  assign bus.led2 = led[2];
  assign bus.led3 = led[3];
  assign bus.led4 = led[4];
  assign bus.led5 = led[5];
  assign bus.led6 = led[6];
  assign bus.led7 = led[7];

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [6:0] m_snap [8];
  logic       m_vld;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [2:0] m_bright;
`endif

  typedef struct {
    int         n;
    logic [7:0] an;
    logic [6:0] seg;
    logic       tick;
    bit         set_pat;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: actual=%h required=%h", name, n, act, exp);
    end
  endtask

  // One clock: the model indexes the schedule by the number of edges since reset release
  task automatic step();
    logic       en_s, rst_s, lit, etick;
    logic [6:0] led_s [8];
    logic [7:0] ean;
    logic [6:0] eseg;
    int s, pos, dig;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [2:0] bright_s;
    bright_s = bus.bright;
`endif
    en_s  = bus.en;
    rst_s = rst;
    led_s = led;
    @(posedge clk);
    #1;
    if (rst_s) begin
      n = 0;
      m_vld = 1'b0;
      for (int i = 0; i < 8; i++) m_snap[i] = 7'h7F;
`ifdef SEG_SCAN_BRIGHTNESS_EN
      m_bright = 3'd7;
`endif
      ean = 8'hFF; eseg = 7'h7F; etick = 1'b0;
    end else begin
      n++;
      s   = n - 1;
      pos = s % SLOT;
      dig = (s / SLOT) % 8;
      lit = en_s && m_vld && (pos >= GUARD);
`ifdef SEG_SCAN_BRIGHTNESS_EN
      lit = lit && ((s % 8) <= int'(m_bright));
`endif
      ean   = lit ? ~(8'd1 << dig) : 8'hFF;
      eseg  = lit ? m_snap[dig] : 7'h7F;
      etick = ((s % FRAME) == FRAME - 1);
      if (etick) begin
        m_snap = led_s;
        m_vld  = 1'b1;
`ifdef SEG_SCAN_BRIGHTNESS_EN
        m_bright = bright_s;
`endif
      end
    end
    check("an", bus.an, ean);
    check("seg", bus.seg, eseg);
    check("frame_tick", bus.frame_tick, etick);
    check("one_anode", 32'($countones(~bus.an) <= 1), 32'd1);
  endtask

  task automatic step_to(input int target);
    int guard_cnt;
    guard_cnt = 0;
    while (n < target && guard_cnt < 20000) begin
      step();
      guard_cnt++;
    end
    check("step_to_reached", n, target);
  endtask

  initial begin
    tbl[0]  = '{64,  8'hFF, 7'h7F, 1'b0, 1'b0};
    tbl[1]  = '{127, 8'hFF, 7'h7F, 1'b0, 1'b0};
    tbl[2]  = '{128, 8'hFF, 7'h7F, 1'b1, 1'b0};
    tbl[3]  = '{130, 8'hFF, 7'h7F, 1'b0, 1'b0};
    tbl[4]  = '{131, 8'hFE, 7'h40, 1'b0, 1'b0};
    tbl[5]  = '{144, 8'hFE, 7'h40, 1'b0, 1'b0};
    tbl[6]  = '{145, 8'hFF, 7'h7F, 1'b0, 1'b0};
    tbl[7]  = '{146, 8'hFF, 7'h7F, 1'b0, 1'b0};
    tbl[8]  = '{147, 8'hFD, 7'h40, 1'b0, 1'b1};
    tbl[9]  = '{256, 8'h7F, 7'h40, 1'b1, 1'b0};
    tbl[10] = '{257, 8'hFF, 7'h7F, 1'b0, 1'b0};
    tbl[11] = '{259, 8'hFE, 7'h00, 1'b0, 1'b0};
    tbl[12] = '{307, 8'hF7, 7'h03, 1'b0, 1'b0};
    tbl[13] = '{384, 8'h7F, 7'h07, 1'b1, 1'b0};
    tbl[14] = '{385, 8'hFF, 7'h7F, 1'b0, 1'b0};

    bus.en = 1'b1;
    for (int i = 0; i < 8; i++) led[i] = 7'h40;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    bus.bright = 3'd7;
`endif
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    for (int k = 0; k < 15; k++) begin
      step_to(tbl[k].n);
      check("tbl_an", bus.an, tbl[k].an);
      check("tbl_seg", bus.seg, tbl[k].seg);
      check("tbl_tick", bus.frame_tick, tbl[k].tick);
      if (tbl[k].set_pat)
        for (int i = 0; i < 8; i++) led[i] = 7'(i);
    end

    // led3 changed during slot 1: old value stays for this frame
    step_to(405);
    led[3] = 7'h12;
    step_to(435);
    check("led3_old_an", bus.an, 8'hF7);
    check("led3_old_seg", bus.seg, 7'h03);
    step_to(563);
    check("led3_new_an", bus.an, 8'hF7);
    check("led3_new_seg", bus.seg, 7'h12);

    // Disable for 40 cycles mid-frame; schedule keeps running underneath
    step_to(600);
    bus.en = 1'b0;
    step();
    check("en_off_an", bus.an, 8'hFF);
    check("en_off_seg", bus.seg, 7'h7F);
    repeat (39) step();
    bus.en = 1'b1;
    step_to(650);
    check("en_resume_an", bus.an, 8'hFE);
    check("en_resume_seg", bus.seg, 7'h00);

    // Reset while digit 5 is lit
    step_to(730);
    check("pre_rst_an", bus.an, 8'hDF);
    rst = 1'b1;
    step();
    check("rst_an", bus.an, 8'hFF);
    check("rst_seg", bus.seg, 7'h7F);
    rst = 1'b0;
    step_to(60);
    check("blank_frame_an", bus.an, 8'hFF);
    step_to(131);
    check("restart_an", bus.an, 8'hFE);
    check("restart_seg", bus.seg, 7'h00);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) led[$urandom_range(0, 7)] = 7'($urandom);
      if ($urandom_range(0, 49) == 0) bus.en = ~bus.en;
      step();
    end
    bus.en = 1'b1;

`ifdef SEG_SCAN_BRIGHTNESS_EN
    bus.bright = 3'd3;
    repeat (3 * FRAME) step();
    bus.bright = 3'd7;
    repeat (2 * FRAME) step();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 99) == 0) bus.bright = 3'($urandom);
      step();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
